// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: reset conditioning, halt/watchdog/budget detection
// and run counters.
module mips_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned HALT_REPEAT  = 3,
    parameter int unsigned WDOG_CYCLES  = 256,
    parameter int unsigned MAX_CYCLES   = 100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        restart_i,
    input  logic        core_retire_i,
    input  logic [31:0] core_pc_i,
    output logic        core_reset_o,
    output logic        running_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] retire_cnt_o
);
    localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned IdleW = $clog2(WDOG_CYCLES + 1);
    localparam int unsigned SameW = $clog2(HALT_REPEAT + 1);

    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(WDOG_CYCLES);
    localparam logic [SameW-1:0] SameMax  = SameW'(HALT_REPEAT);
    localparam logic [31:0]      CycMax   = 32'(MAX_CYCLES);

    typedef enum logic [1:0] {StHold, StRun, StHalt, StTout} state_e;

    state_e           state_q;
    logic [1:0]       sync_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;
    logic [31:0]      retire_cnt_q, retire_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [SameW-1:0] same_cnt_q, same_cnt_d;
    logic [31:0]      last_pc_q;
    logic             last_valid_q;
    logic             core_reset_q, running_q, done_q, timeout_q;

    // Counter values a RUN cycle would produce; exits are judged on these.
    always_comb begin
        cycle_cnt_d  = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
        retire_cnt_d = retire_cnt_q;
        idle_cnt_d   = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleW'(1);
        same_cnt_d   = same_cnt_q;
        if (core_retire_i) begin
            retire_cnt_d = (retire_cnt_q == '1) ? retire_cnt_q : retire_cnt_q + 32'd1;
            idle_cnt_d   = '0;
            if (last_valid_q && (core_pc_i == last_pc_q)) begin
                same_cnt_d = (same_cnt_q == SameMax) ? same_cnt_q : same_cnt_q + SameW'(1);
            end else begin
                same_cnt_d = SameW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StHold;
            sync_q       <= 2'b00;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            idle_cnt_q   <= '0;
            same_cnt_q   <= '0;
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
            if (restart_i) begin
                state_q      <= StHold;
                hold_cnt_q   <= '0;
                cycle_cnt_q  <= '0;
                retire_cnt_q <= '0;
                idle_cnt_q   <= '0;
                same_cnt_q   <= '0;
                last_valid_q <= 1'b0;
                core_reset_q <= 1'b1;
                running_q    <= 1'b0;
                done_q       <= 1'b0;
                timeout_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StHold: begin
                        if (sync_q[1]) begin
                            if (hold_cnt_q == HoldLast) begin
                                state_q      <= StRun;
                                core_reset_q <= 1'b0;
                                running_q    <= 1'b1;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + HoldW'(1);
                            end
                        end
                    end
                    StRun: begin
                        cycle_cnt_q  <= cycle_cnt_d;
                        retire_cnt_q <= retire_cnt_d;
                        idle_cnt_q   <= idle_cnt_d;
                        same_cnt_q   <= same_cnt_d;
                        if (core_retire_i) begin
                            last_pc_q    <= core_pc_i;
                            last_valid_q <= 1'b1;
                        end
                        if (same_cnt_d == SameMax) begin
                            state_q   <= StHalt;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else if ((idle_cnt_d == IdleMax) || (cycle_cnt_d == CycMax)) begin
                            state_q   <= StTout;
                            running_q <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
                    // Terminal: counters frozen, core left running so its state stays visible.
                    StHalt, StTout: ;
                    default: state_q <= StHold;
                endcase
            end
        end
    end

    assign core_reset_o = core_reset_q;
    assign running_o    = running_q;
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances (default budget and a 50-cycle budget) driven
// identically and compared against a history-based reference model.
module tb_mips_run_ctrl;
    localparam int     RESET_CYCLES = 4;
    localparam int     HALT_REPEAT  = 3;
    localparam longint WDOG_CYCLES  = 256;
    localparam longint MAX_A        = 100000;
    localparam longint MAX_B        = 50;
    localparam longint SAT          = 64'h0000_0000_FFFF_FFFF;
    localparam int     PH_HOLD = 0, PH_RUN = 1, PH_HALT = 2, PH_TOUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] pc = 32'd0;

    logic        a_core_reset, a_running, a_done, a_timeout;
    logic [31:0] a_cyc, a_ret;
    logic        b_core_reset, b_running, b_done, b_timeout;
    logic [31:0] b_cyc, b_ret;

    always #5 clk = ~clk;

    mips_run_ctrl #(.MAX_CYCLES(100000)) u_dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .restart_i    (restart),
        .core_retire_i(retire),
        .core_pc_i    (pc),
        .core_reset_o (a_core_reset),
        .running_o    (a_running),
        .done_o       (a_done),
        .timeout_o    (a_timeout),
        .cycle_cnt_o  (a_cyc),
        .retire_cnt_o (a_ret)
    );

    mips_run_ctrl #(.MAX_CYCLES(50)) u_dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .restart_i    (restart),
        .core_retire_i(retire),
        .core_pc_i    (pc),
        .core_reset_o (b_core_reset),
        .running_o    (b_running),
        .done_o       (b_done),
        .timeout_o    (b_timeout),
        .cycle_cnt_o  (b_cyc),
        .retire_cnt_o (b_ret)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase, edges since reset release, hold progress, counters,
    // and the recent retired-PC history of the current run.
    int          m_phase[2];
    int          m_rel[2];
    int          m_hold[2];
    longint      m_cyc[2], m_ret[2], m_idle[2];
    logic [31:0] m_pcs0[$];
    logic [31:0] m_pcs1[$];

    localparam logic [67:0] RESET_VIEW = {1'b1, 3'b000, 64'd0};

    function automatic logic [67:0] obs(input int i);
        if (i == 0) return {a_core_reset, a_running, a_done, a_timeout, a_cyc, a_ret};
        return {b_core_reset, b_running, b_done, b_timeout, b_cyc, b_ret};
    endfunction

    function automatic logic [67:0] expv(input int i);
        return {m_phase[i] == PH_HOLD, m_phase[i] == PH_RUN, m_phase[i] == PH_HALT,
                m_phase[i] == PH_TOUT, 32'(m_cyc[i]), 32'(m_ret[i])};
    endfunction

    // Halt when the last HALT_REPEAT retires of this run all share one PC.
    function automatic bit hist_halt(input int i);
        logic [31:0] q[$];
        if (i == 0) q = m_pcs0;
        else q = m_pcs1;
        if (q.size() < HALT_REPEAT) return 1'b0;
        for (int k = 1; k < HALT_REPEAT; k++)
            if (q[q.size() - 1 - k] != q[q.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_hist(input int i);
        if (i == 0) m_pcs0.delete();
        else m_pcs1.delete();
    endtask

    task automatic model_reset(input int i);
        m_phase[i] = PH_HOLD;
        m_rel[i]   = 0;
        m_hold[i]  = 0;
        m_cyc[i]   = 0;
        m_ret[i]   = 0;
        m_idle[i]  = 0;
        clear_hist(i);
    endtask

    task automatic model_edge(input int i, input logic rs, input logic ret, input logic [31:0] p);
        longint mx = (i == 0) ? MAX_A : MAX_B;
        bit released = (m_rel[i] >= 2);
        if (m_rel[i] < 8) m_rel[i]++;
        if (rs) begin
            m_phase[i] = PH_HOLD;
            m_hold[i]  = 0;
            m_cyc[i]   = 0;
            m_ret[i]   = 0;
            m_idle[i]  = 0;
            clear_hist(i);
        end else if (m_phase[i] == PH_HOLD) begin
            if (released) begin
                m_hold[i]++;
                if (m_hold[i] == RESET_CYCLES) m_phase[i] = PH_RUN;
            end
        end else if (m_phase[i] == PH_RUN) begin
            if (m_cyc[i] < SAT) m_cyc[i]++;
            if (ret) begin
                if (m_ret[i] < SAT) m_ret[i]++;
                m_idle[i] = 0;
                if (i == 0) begin
                    m_pcs0.push_back(p);
                    if (m_pcs0.size() > HALT_REPEAT) void'(m_pcs0.pop_front());
                end else begin
                    m_pcs1.push_back(p);
                    if (m_pcs1.size() > HALT_REPEAT) void'(m_pcs1.pop_front());
                end
            end else begin
                m_idle[i]++;
            end
            if (hist_halt(i)) m_phase[i] = PH_HALT;
            else if (m_idle[i] >= WDOG_CYCLES || m_cyc[i] >= mx) m_phase[i] = PH_TOUT;
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic tick(input logic rs, input logic ret, input logic [31:0] p);
        restart = rs;
        retire  = ret;
        pc      = p;
        @(posedge clk);
        model_edge(0, rs, ret, p);
        model_edge(1, rs, ret, p);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset(0);
        model_reset(1);
        n_checks++;
        if (obs(0) !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", obs(0), RESET_VIEW);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1'b0, 1'b0, 32'd0);
            n_checks++;
            if (obs(0) !== expv(0)) begin
                n_fail++;
                $display("FAIL reset_edge%0d: got %h want %h", e, obs(0), expv(0));
            end
            if (e == 5) begin
                n_checks++;
                if (a_core_reset !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_edge5_core_reset: got %b want 1", a_core_reset);
                end
            end
            if (e == 6) begin
                n_checks++;
                if ({a_core_reset, a_running, a_cyc} !== {1'b0, 1'b1, 32'd0}) begin
                    n_fail++;
                    $display("FAIL reset_edge6_release: got %b %b %0d want 0 1 0",
                             a_core_reset, a_running, a_cyc);
                end
            end
            if (e == 7) begin
                n_checks++;
                if (a_cyc !== 32'd1) begin
                    n_fail++;
                    $display("FAIL reset_edge7_cycle: got %0d want 1", a_cyc);
                end
            end
        end
    endtask

    task automatic test_halt;
        logic [31:0] seq [5];
        seq = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008};
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, seq[k]);
            n_checks++;
            if (obs(0) !== expv(0)) begin
                n_fail++;
                $display("FAIL halt_step%0d: got %h want %h", k, obs(0), expv(0));
            end
            if (k == 3) begin
                n_checks++;
                if (a_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_early: done got %b want 0", a_done);
                end
            end
        end
        n_checks++;
        if ({a_done, a_running, a_ret} !== {1'b1, 1'b0, 32'd5}) begin
            n_fail++;
            $display("FAIL halt_detect: done %b running %b retire %0d want 1 0 5",
                     a_done, a_running, a_ret);
        end
        repeat (5) tick(1'b0, 1'b1, 32'h3010);
        n_checks++;
        if ({a_done, a_cyc, a_ret} !== {1'b1, 32'd6, 32'd5}) begin
            n_fail++;
            $display("FAIL halt_freeze: done %b cycle %0d retire %0d want 1 6 5",
                     a_done, a_cyc, a_ret);
        end
    endtask

    task automatic test_restart;
        tick(1'b1, 1'b0, 32'd0);
        n_checks++;
        if (obs(0) !== RESET_VIEW) begin
            n_fail++;
            $display("FAIL restart_pulse: got %h want %h", obs(0), RESET_VIEW);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 32'd0);
            n_checks++;
            if ({a_core_reset, a_running} !== {k < 4, k == 4}) begin
                n_fail++;
                $display("FAIL restart_hold%0d: core_reset %b running %b", k, a_core_reset,
                         a_running);
            end
        end
        repeat (3) tick(1'b1, 1'b1, 32'h10);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 32'd0);
            n_checks++;
            if (obs(0) !== expv(0) || a_running !== (k == 4)) begin
                n_fail++;
                $display("FAIL restart_held%0d: got %h want %h", k, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_watchdog;
        tick(1'b0, 1'b1, 32'h40);
        for (int k = 1; k <= 255; k++) tick(1'b0, 1'b0, 32'd0);
        n_checks++;
        if (a_timeout !== 1'b0 || obs(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL wdog_early: got %h want %h", obs(0), expv(0));
        end
        tick(1'b0, 1'b0, 32'd0);
        n_checks++;
        if ({a_timeout, a_done, a_running, a_ret} !== {1'b1, 1'b0, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL wdog_fire: timeout %b done %b running %b retire %0d want 1 0 0 1",
                     a_timeout, a_done, a_running, a_ret);
        end
    endtask

    task automatic test_budget;
        tick(1'b1, 1'b0, 32'd0);
        repeat (4) tick(1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, 1'b1, 32'h1000 + 32'(4 * k));
            n_checks++;
            if (b_timeout !== (k == 50) || obs(1) !== expv(1)) begin
                n_fail++;
                $display("FAIL budget_step%0d: got %h want %h", k, obs(1), expv(1));
            end
        end
        n_checks++;
        if ({b_cyc, b_ret, a_running} !== {32'd50, 32'd50, 1'b1}) begin
            n_fail++;
            $display("FAIL budget_counts: cycle %0d retire %0d a_running %b want 50 50 1",
                     b_cyc, b_ret, a_running);
        end
    endtask

    task automatic test_collision;
        tick(1'b1, 1'b0, 32'd0);
        repeat (4) tick(1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 32'h200);
        tick(1'b0, 1'b1, 32'h200);
        tick(1'b1, 1'b1, 32'h200);
        n_checks++;
        if ({a_core_reset, a_done, a_ret} !== {1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL collision_hold: core_reset %b done %b retire %0d want 1 0 0",
                     a_core_reset, a_done, a_ret);
        end
        repeat (4) tick(1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 32'h200);
        tick(1'b0, 1'b1, 32'h200);
        n_checks++;
        if (a_done !== 1'b0 || obs(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL collision_history_cleared: got %h want %h", obs(0), expv(0));
        end
        tick(1'b0, 1'b1, 32'h200);
        n_checks++;
        if (a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_rehalt: done got %b want 1", a_done);
        end
    endtask

    task automatic test_random;
        for (int seg = 0; seg < 5; seg++) begin
            int thr = (seg == 2) ? 0 : ((seg % 2 == 0) ? 9 : 5);
            int rmod = (seg == 2) ? 400 : 60;
            for (int c = 0; c < 300; c++) begin
                logic rs = ($urandom_range(0, rmod - 1) == 0);
                logic rt = ($urandom_range(0, 9) < thr);
                logic [31:0] p = 32'h100 + 32'(4 * $urandom_range(0, 3));
                tick(rs, rt, p);
                for (int i = 0; i < 2; i++) begin
                    n_checks++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL random_seg%0d_cyc%0d_inst%0d: got %h want %h", seg, c, i,
                                 obs(i), expv(i));
                    end
                end
            end
        end
    endtask

    task automatic test_midrun_reset;
        int guard = 0;
        tick(1'b1, 1'b0, 32'd0);
        repeat (4) tick(1'b0, 1'b0, 32'd0);
        while (m_cyc[0] < 20 && guard < 100) begin
            tick(1'b0, 1'b1, 32'h5000 + 32'(4 * guard));
            guard++;
        end
        n_checks++;
        if (a_cyc !== 32'd20 || a_running !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reach20: cycle %0d running %b want 20 1", a_cyc, a_running);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== RESET_VIEW) begin
                n_fail++;
                $display("FAIL midrun_async_inst%0d: got %h want %h", i, obs(i), RESET_VIEW);
            end
        end
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1'b0, 1'b0, 32'd0);
            n_checks++;
            if (obs(0) !== expv(0) || a_running !== (e >= 6)) begin
                n_fail++;
                $display("FAIL midrun_rerelease%0d: got %h want %h", e, obs(0), expv(0));
            end
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        #1;
        test_reset();
        test_halt();
        test_restart();
        test_watchdog();
        test_budget();
        test_collision();
        test_random();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Run controller between the board/bench clock-reset source and the `mips` core.
- Conditions the external asynchronous active-low reset into a synchronous, stretched, active-high `core_reset` for the core.
- Watches the core's retire stream and detects three end conditions: program halt (jump-to-self loop), watchdog stall, and cycle-budget overrun.
- Exposes cycle and retire counters so simulation and board runs end deterministically.

Parameters:
- RESET_CYCLES, 4: cycles `core_reset` is held after the synchronised reset release; must be >= 1.
- HALT_REPEAT, 3: consecutive retires at an identical PC that declare a halt; must be >= 2.
- WDOG_CYCLES, 256: consecutive cycles with no retire that declare a timeout.
- MAX_CYCLES, 100000: run-cycle budget that declares a timeout.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- restart, input, 1: synchronous one-cycle pulse; restarts the core from any state.
- core_retire, input, 1: core committed one instruction this cycle.
- core_pc, input, 32: PC of the retiring instruction; valid only when `core_retire`=1.
- core_reset, output, 1: synchronous active-high reset to the `mips` core.
- running, output, 1: high in the RUN state.
- done, output, 1: high in the HALT state.
- timeout, output, 1: high in the TOUT state.
- cycle_cnt, output, 32: cycles spent in RUN since the last hold.
- retire_cnt, output, 32: instructions retired since the last hold.

Behaviour:
Reset synchroniser
- Two-flop synchroniser, both flops cleared asynchronously when `reset`=0.
- Release takes effect on the 2nd rising edge after `reset` rises.
- While `reset`=0, all state and outputs are forced asynchronously to their reset values:
  - state = HOLD, `core_reset`=1;
  - `running`, `done`, `timeout` = 0;
  - all counters = 0.

State machine (HOLD, RUN, HALT, TOUT)
- HOLD:
  - `core_reset`=1; `hold_cnt` increments each cycle after the synchroniser releases.
  - When `hold_cnt` = RESET_CYCLES-1, go to RUN.
  - `core_reset` first reads 0 exactly 2+RESET_CYCLES rising edges after `reset` rises (6 with defaults).
- RUN:
  - `core_reset`=0, `running`=1.
  - `cycle_cnt` +1 every cycle.
  - `retire_cnt` +1 on each `core_retire`.
  - `idle_cnt` +1 on cycles without `core_retire`; cleared on `core_retire`.
  - On `core_retire`: if `core_pc` equals `last_pc` and `last_valid`=1, `same_cnt` +1; otherwise `same_cnt`=1. Then `last_pc`=`core_pc` and `last_valid`=1.
- Exit from RUN, evaluated on the updated values; the first matching line wins:
  - `same_cnt` reaches HALT_REPEAT: go to HALT.
  - `idle_cnt` reaches WDOG_CYCLES: go to TOUT.
  - `cycle_cnt` reaches MAX_CYCLES: go to TOUT.
  - Consequence: if halt and timeout coincide in one cycle, HALT wins.
- HALT / TOUT:
  - Terminal states; all counters freeze.
  - `core_reset` stays 0, so the core keeps looping and architectural state remains visible.
  - `done` or `timeout` stays high until `restart` or `reset`.
- `restart`, any state:
  - Next state HOLD; `hold_cnt`, `cycle_cnt`, `retire_cnt`, `idle_cnt`, `same_cnt` and `last_valid` are cleared; `core_reset`=1 on the next edge.
  - `restart` held over several cycles keeps HOLD and keeps `hold_cnt` at 0.
  - `restart` outranks every RUN exit in the same cycle.
- Counter width rules:
  - `cycle_cnt` and `retire_cnt` saturate at 32'hFFFFFFFF and never wrap.
  - `idle_cnt` and `same_cnt` are only wide enough for their parameter and stop at their limit.
- `reset` asserted mid-run: immediate asynchronous return to the reset values; the core sees `core_reset`=1 in the same cycle (combinational path from the asynchronous clear of the `core_reset` flop only).
- Outputs are registered; `running`, `done` and `timeout` are one-hot or all zero (all zero in HOLD).

Test Plan:
- Reset release:
  - Stimulus: `reset`=0 for 3 cycles, then 1, with defaults.
  - Required: `core_reset` falls on edge 6; `running`=1 on the same edge; `cycle_cnt`=0 then 1 on edge 7.
- Halt detect:
  - Stimulus: after RUN, retire PCs 0x3000, 0x3004, 0x3008, 0x3008, 0x3008.
  - Required: `done`=1 after the 5th retire; `retire_cnt`=5; counters freeze.
- Watchdog:
  - Stimulus: one retire, then `core_retire`=0 for 256 cycles.
  - Required: `timeout`=1 on the 256th idle cycle; `done`=0; `retire_cnt`=1.
- Cycle budget:
  - Stimulus: MAX_CYCLES=50; retire every cycle with incrementing PC.
  - Required: `timeout`=1 when `cycle_cnt`=50; `retire_cnt`=50.
- Restart and collision:
  - Stimulus 1: pulse `restart` while in HALT. Required: `core_reset`=1 next edge, counters 0, RUN again after 4 cycles.
  - Stimulus 2: assert `restart` in the same cycle as the 3rd identical PC. Required: HOLD is taken, not HALT.
- Mid-run reset:
  - Stimulus: drop `reset` at `cycle_cnt`=20.
  - Required: `core_reset`=1, `running`=0 and counters=0 without waiting for a clock edge.
